// File: rtl/fc_logit_argmax_pkg.sv
// Shared NPU constants and types for the FC-layer logit sink.
package fc_logit_argmax_pkg;

  localparam int OUTPUT_NUM = 10;  // classes per frame, must be >= 2
  localparam int DATA_W     = 12;  // signed logit width
  localparam int IDX_W      = 4;   // ceil(log2(OUTPUT_NUM))
  localparam int FCNT_W     = 16;  // completed-frame counter width

  typedef logic signed [DATA_W-1:0] logit_t;
  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [DATA_W-1:0]        margin_t;
  typedef logic [FCNT_W-1:0]        fcnt_t;

  // Most negative logit; seeds the runner-up at the first sample of a frame.
  localparam logit_t LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // max - second in DATA_W+1 bits; max >= second, so the low DATA_W bits hold it.
  function automatic margin_t top2_margin(input logit_t max_v, input logit_t sec_v);
    logic signed [DATA_W:0] diff;
    diff = {max_v[DATA_W-1], max_v} - {sec_v[DATA_W-1], sec_v};
    return diff[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_logit_argmax_if.sv
// Logit stream, buffer read port and result bus of the argmax sink.
interface fc_logit_argmax_if;
  import fc_logit_argmax_pkg::*;

  logic    valid_in;
  logit_t  data_in;
  logic    clear;
  idx_t    rd_addr;
  logit_t  rd_data;
  idx_t    class_idx;
  logit_t  max_logit;
  margin_t margin;
  logic    valid_out;
  logic    busy;
  fcnt_t   frame_cnt;

  // Upstream FC layer / host side
  modport master (
    output valid_in, data_in, clear, rd_addr,
    input  rd_data, class_idx, max_logit, margin, valid_out, busy, frame_cnt
  );

  // Argmax block side
  modport slave (
    input  valid_in, data_in, clear, rd_addr,
    output rd_data, class_idx, max_logit, margin, valid_out, busy, frame_cnt
  );

endinterface

// File: rtl/fc_top2_tracker.sv
// Running top-2 tracker: largest logit, its index and the runner-up.
module fc_top2_tracker
  import fc_logit_argmax_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   upd,        // accepted sample this cycle
  input  logic   first,      // sample is the first of its frame
  input  idx_t   k,          // sample index within the frame
  input  logit_t x,
  output logit_t max_val,
  output logit_t second_val,
  output idx_t   max_idx
);

  logit_t max_reg;
  logit_t second_reg;
  idx_t   idx_reg;

  // Strict greater-than on the max keeps the lower index on ties; an equal
  // value falls through to the runner-up so the margin becomes zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_reg    <= '0;
      second_reg <= '0;
      idx_reg    <= '0;
    end else if (upd) begin
      if (first) begin
        max_reg    <= x;
        second_reg <= LOGIT_MIN;
        idx_reg    <= '0;
      end else if (x > max_reg) begin
        second_reg <= max_reg;
        max_reg    <= x;
        idx_reg    <= k;
      end else if (x > second_reg) begin
        second_reg <= x;
      end
    end
  end

  assign max_val    = max_reg;
  assign second_val = second_reg;
  assign max_idx    = idx_reg;

endmodule

// File: rtl/fc_logit_argmax.sv
// Terminal NPU block: collects one frame of logits, buffers them and
// reports the argmax class, its logit and the top-2 margin.
module fc_logit_argmax
  import fc_logit_argmax_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fc_logit_argmax_if.slave  bus
);

  state_t  state_reg;
  idx_t    cnt_reg;
  logic    busy_reg;
  logic    done_reg;
  logit_t  buf_reg [OUTPUT_NUM];
  logit_t  rd_data_reg;
  idx_t    class_idx_reg;
  logit_t  max_logit_reg;
  margin_t margin_reg;
  logic    valid_out_reg;
  fcnt_t   frame_cnt_reg;

  logit_t  trk_max;
  logit_t  trk_second;
  idx_t    trk_idx;

  logic accept;
  logic first_sample;
  logic last_sample;

  assign accept       = bus.valid_in && !bus.clear;
  assign first_sample = (cnt_reg == '0);
  assign last_sample  = accept && (cnt_reg == idx_t'(OUTPUT_NUM - 1));

  fc_top2_tracker u_top2 (
    .clk        (clk),
    .rst        (rst),
    .upd        (accept),
    .first      (first_sample),
    .k          (cnt_reg),
    .x          (bus.data_in),
    .max_val    (trk_max),
    .second_val (trk_second),
    .max_idx    (trk_idx)
  );

  // Frame FSM: sample counter, busy flag and the one-cycle result strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      // A completed frame still reports even if clear follows immediately.
      done_reg <= last_sample;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg <= ST_COLLECT;
            cnt_reg   <= idx_t'(1);
            busy_reg  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (bus.clear || last_sample) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (accept) begin
            cnt_reg   <= cnt_reg + idx_t'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Logit buffer write; the counter always addresses a valid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_NUM; i++) buf_reg[i] <= '0;
    end else if (accept) begin
      buf_reg[cnt_reg] <= bus.data_in;
    end
  end

  // Registered buffer read; sees the pre-write contents on a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if ({1'b0, bus.rd_addr} < (IDX_W + 1)'(OUTPUT_NUM)) begin
      rd_data_reg <= buf_reg[bus.rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  // Result stage: samples the tracker one edge after the last logit, so a
  // new frame's first update on that same edge cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_idx_reg <= '0;
      max_logit_reg <= '0;
      margin_reg    <= '0;
      valid_out_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (done_reg) begin
      class_idx_reg <= trk_idx;
      max_logit_reg <= trk_max;
      margin_reg    <= top2_margin(trk_max, trk_second);
      valid_out_reg <= 1'b1;
      frame_cnt_reg <= frame_cnt_reg + fcnt_t'(1);
    end else begin
      valid_out_reg <= 1'b0;
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.class_idx = class_idx_reg;
  assign bus.max_logit = max_logit_reg;
  assign bus.margin    = margin_reg;
  assign bus.valid_out = valid_out_reg;
  assign bus.busy      = busy_reg;
  assign bus.frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fc_logit_argmax.sv
// Scoreboard bench for fc_logit_argmax: stimulus pushes expected frame
// results, a monitor pops and compares on every valid_out.
module tb_fc_logit_argmax;
  import fc_logit_argmax_pkg::*;

  typedef struct {
    int      cyc;
    idx_t    idx;
    logit_t  mx;
    margin_t mg;
    fcnt_t   fc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  exp_t  sb[$];
  fcnt_t exp_fcnt = '0;
  int    sent[OUTPUT_NUM];

  fc_logit_argmax_if bus();

  fc_logit_argmax dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: winner is the largest value at its lowest index; runner-up is
  // the largest of the remaining entries.
  function automatic exp_t model(input int v[OUTPUT_NUM]);
    exp_t e;
    int best = 0;
    int sec = -(1 <<< (DATA_W - 1));
    for (int i = 1; i < OUTPUT_NUM; i++) if (v[i] > v[best]) best = i;
    for (int i = 0; i < OUTPUT_NUM; i++) if (i != best && v[i] > sec) sec = v[i];
    e.cyc = 0;
    e.fc  = '0;
    e.idx = idx_t'(best);
    e.mx  = logit_t'(v[best]);
    e.mg  = margin_t'(v[best] - sec);
    return e;
  endfunction

  task automatic send_frame(input int v[OUTPUT_NUM], input int max_gap);
    exp_t e;
    for (int i = 0; i < OUTPUT_NUM; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.clear    = 1'b0;
      end
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.clear    = 1'b0;
      bus.data_in  = logit_t'(v[i]);
    end
    e = model(v);
    e.cyc = cyc + 2;           // result visible one edge after the last sample
    exp_fcnt = exp_fcnt + fcnt_t'(1);
    e.fc = exp_fcnt;
    sb.push_back(e);
    sent = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.clear    = 1'b0;
    end
  endtask

  function automatic int rnd_logit();
    if ($urandom_range(1, 0) == 0) return int'($urandom_range(8, 0)) - 4;
    return int'($urandom_range(4095, 0)) - 2048;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_out"}, longint'(bus.valid_out), 0);
    check({tag, "_busy"},      longint'(bus.busy), 0);
    check({tag, "_class_idx"}, longint'(bus.class_idx), 0);
    check({tag, "_max_logit"}, longint'(bus.max_logit), 0);
    check({tag, "_margin"},    longint'(bus.margin), 0);
    check({tag, "_frame_cnt"}, longint'(bus.frame_cnt), 0);
    check({tag, "_rd_data"},   longint'(bus.rd_data), 0);
  endtask

  initial begin
    int pat[OUTPUT_NUM];
    int pat_b[OUTPUT_NUM];
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.clear    = 1'b0;
    bus.rd_addr  = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst && bus.valid_out) begin
            if (sb.size() == 0) begin
              check("unexpected_valid_out", 1, 0);
            end else begin
              e = sb.pop_front();
              $display("result: cycle %0d class %0d logit %0d margin %0d frames %0d",
                       cyc, bus.class_idx, bus.max_logit, bus.margin, bus.frame_cnt);
              check("latency",   cyc, e.cyc);
              check("class_idx", longint'(bus.class_idx), longint'(e.idx));
              check("max_logit", longint'(bus.max_logit), longint'(e.mx));
              check("margin",    longint'(bus.margin), longint'(e.mg));
              check("frame_cnt", longint'(bus.frame_cnt), longint'(e.fc));
            end
          end
        end
      end
    join_none

    // Reset state
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Tie keeps lower index, margin 0
    pat = '{5, -3, 100, 7, 100, -2048, 0, 99, 1, 2};
    send_frame(pat, 0);
    idle(3);

    // All minimum
    for (int i = 0; i < OUTPUT_NUM; i++) pat[i] = -2048;
    send_frame(pat, 0);
    idle(2);

    // Max at last index, full-range margin
    pat[OUTPUT_NUM-1] = 2047;
    send_frame(pat, 1);
    idle(2);

    // Back-to-back frames with no dead cycle
    pat   = '{0, 10, 20, 50, -1, 3, 2, 1, 0, -9};
    pat_b = '{1, 2, 3, 4, 0, -5, -1, 9, 2, -7};
    send_frame(pat, 0);
    send_frame(pat_b, 0);
    idle(3);

    // Partial frame aborted by clear with a simultaneous (dropped) sample
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.data_in  = logit_t'(2000 + i);
    end
    @(negedge clk);
    check("busy_partial", longint'(bus.busy), 1);
    bus.valid_in = 1'b1;
    bus.data_in  = logit_t'(2047);
    bus.clear    = 1'b1;
    @(negedge clk);
    check("busy_after_clear", longint'(bus.busy), 0);
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
    for (int i = 0; i < OUTPUT_NUM; i++) pat[i] = int'($urandom_range(1000, 0)) - 500;
    send_frame(pat, 0);
    idle(3);

    // Randomized frames, some back-to-back, some gapped
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < OUTPUT_NUM; i++) pat[i] = rnd_logit();
      send_frame(pat, (f % 2 == 0) ? 3 : 0);
    end
    idle(3);

    // Buffer readback of the last frame, then an out-of-range address
    for (int a = 0; a < OUTPUT_NUM; a++) begin
      @(negedge clk);
      bus.rd_addr = idx_t'(a);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", a), longint'(bus.rd_data), longint'(sent[a]));
    end
    @(negedge clk);
    bus.rd_addr = idx_t'(12);
    @(negedge clk);
    check("rd_data_oob", longint'(bus.rd_data), 0);
    check("results_drained", sb.size(), 0);

    // Reset in the middle of a frame
    bus.rd_addr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.valid_in = ($urandom_range(1, 0) == 1);
      bus.data_in  = logit_t'(rnd_logit());
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    #1 check_all_zero("midrst");
    exp_fcnt = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(15);

    // Fresh frame after reset restarts the frame count
    for (int i = 0; i < OUTPUT_NUM; i++) pat[i] = rnd_logit();
    send_frame(pat, 2);
    idle(4);
    check("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_logit_argmax.md
Name: fc_logit_argmax

Overview:
- Sink for the sequential logit stream from the fully-connected layer: one signed 12b logit per valid pulse, OUTPUT_NUM pulses per inference.
- Keeps a running argmax, the runner-up and a logit buffer.
- After the last logit of a frame, emits the predicted class, its logit and the top-2 margin with a 1-cycle valid pulse.
- Terminal block of the NPU datapath; its results feed the host/status interface.

Parameters:
- OUTPUT_NUM, 10, logits per frame (number of classes); must be >= 2
- DATA_W, 12, logit width in bits, signed
- IDX_W, 4, class index width; equals ceil(log2(OUTPUT_NUM))
- FCNT_W, 16, width of the frame counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  logit strobe; one pulse per logit, gaps allowed
- data_in  in  DATA_W  signed logit
- clear  in  1  synchronous frame abort: return to IDLE, discard partial frame
- rd_addr  in  IDX_W  logit buffer read address
- rd_data  out  DATA_W  registered buffer read data
- class_idx  out  IDX_W  winning class of last completed frame
- max_logit  out  DATA_W  winning logit
- margin  out  DATA_W  unsigned, max_logit minus runner-up logit
- valid_out  out  1  1-cycle pulse when a frame's result updates
- busy  out  1  high while a frame is partially received
- frame_cnt  out  FCNT_W  number of completed frames; wraps modulo 2^FCNT_W

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, cnt=0, buffer cleared to 0.
- States:
  - IDLE: cnt=0, busy=0.
  - COLLECT: 0 < cnt < OUTPUT_NUM, busy=1.
- Sample k (0-based) is the k-th valid_in pulse since IDLE. Each accepted sample:
  - writes buf[k] = data_in;
  - cnt increments.
- Running update, all compares signed:
  - k=0: max=x, idx=0, second=-2^(DATA_W-1).
  - k>0, x > max (strict): second=max, max=x, idx=k.
  - k>0, otherwise if x > second: second=x.
  - Ties keep the lower index.
- Frame completion (k = OUTPUT_NUM-1 accepted):
  - State returns to IDLE on the same edge.
  - On the next edge the result registers load and valid_out=1 for exactly 1 cycle. Latency is 1 cycle from the last valid_in edge.
  - frame_cnt increments with that valid_out.
- Result registers (class_idx, max_logit, margin) hold until the next frame completes.
  - margin = max - second, computed in DATA_W+1 bits; it always fits in DATA_W unsigned bits.
- A new frame may start on the cycle directly after the last sample. Back-to-back frames run with no dead cycle, and the result pipeline stage must not corrupt the next frame's first update.
- clear=1:
  - cnt->0, state->IDLE; running max/second/idx are invalidated.
  - A valid_in on the same cycle is dropped.
  - The buffer, result registers and frame_cnt are untouched.
  - A pending valid_out (last sample on the previous edge) still fires.
- rd_data is registered, 1-cycle latency.
  - It returns the buffer value before any write on the same edge (read-before-write).
  - rd_addr >= OUTPUT_NUM returns 0.
- No backpressure: the upstream cannot be stalled, and every valid_in outside a clear is accepted.
- rst asserted mid-frame aborts immediately; no valid_out is produced for the partial frame.

Decomposition:
- Shared NPU package holds:
  - the OUTPUT_NUM/DATA_W constants shared with the FC layer;
  - the signed logit typedef;
  - the localparam LOGIT_MIN = -2^(DATA_W-1).
- One natural sub-module: fc_top2_tracker (the registered max/second/idx update with tie rule). The buffer and FSM stay in the top.

Test Plan:
- Logits 5,-3,100,7,100,-2048,0,99,1,2 -> 1 cycle after the 10th pulse: valid_out=1, class_idx=2 (tie keeps lower index), max_logit=100, margin=0, frame_cnt=1.
- All ten logits = -2048 -> class_idx=0, max_logit=-2048, margin=0.
- Logits 2047 at index 9, others -2048 -> class_idx=9, max_logit=2047, margin=4095.
- Two back-to-back frames, no gap:
  - frame A max 50 at index 3;
  - frame B max 9 at index 7, runner-up 4;
  - -> two valid_out pulses 10 cycles apart, second shows class_idx=7, margin=5, frame_cnt=2.
- 4 samples, then clear with a simultaneous valid_in, then a full 10-sample frame -> exactly one valid_out, computed only from the 10 post-clear samples.
- Frame with random gaps in valid_in:
  - read rd_addr 0..9 afterwards -> rd_data matches each sent logit 1 cycle later;
  - rd_addr=12 -> 0.
  - Then assert rst mid-frame -> all outputs 0 and no valid_out.
